// File: rtl/sram_mbist_march_ctrl.sv
// March C- memory BIST controller driving one single-port SRAM RW port.
// Define MBIST_DIAG_EN to keep first-fail address/element and a saturating mismatch count.
module sram_mbist_march_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 9,
  parameter logic [DATA_WIDTH-1:0] DATA_BG    = '0
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  start,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  input  logic [DATA_WIDTH-1:0] mem_dout0,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [15:0]           fail_cnt
);

  // state | meaning
  // IDLE  | waiting for start, SRAM deselected
  // RUN   | one March command per cycle, no bubbles
  // DRAIN | SRAM deselected, last reads still in the compare pipeline
  // DONE  | result held until the next start

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state, state_nxt;
  logic [2:0]              elem, elem_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic                    phase, phase_nxt;
  logic                    drain_last, drain_last_nxt;
  logic                    csb_nxt, web_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [DATA_WIDTH-1:0]   din_nxt;
  logic                    busy_nxt, done_nxt;
  logic                    launch, issue_rd;

  logic                    two_op, is_read, desc, op_inv, last_cmd;
  logic [DATA_WIDTH-1:0]   op_data;
  logic [ADDR_WIDTH-1:0]   op_addr;

  logic                    rd_v1, rd_v2;
  logic [DATA_WIDTH-1:0]   rd_exp1, rd_exp2;
  logic                    mismatch;

  // Elements 1-4 are read-then-write per address; 3 and 4 walk downwards.
  always_comb begin
    two_op   = (elem != 3'd0) && (elem != 3'd5);
    is_read  = (elem == 3'd5) || (two_op && !phase);
    desc     = (elem == 3'd3) || (elem == 3'd4);
    op_inv   = is_read ? ((elem == 3'd2) || (elem == 3'd4))
                       : ((elem == 3'd1) || (elem == 3'd3));
    op_data  = op_inv ? ~DATA_BG : DATA_BG;
    op_addr  = desc ? ~cnt : cnt;
    last_cmd = (elem == 3'd5) && (cnt == CNT_MAX);
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state      <= S_IDLE;
      elem       <= '0;
      cnt        <= '0;
      phase      <= 1'b0;
      drain_last <= 1'b0;
      mem_csb0   <= 1'b1;
      mem_web0   <= 1'b1;
      mem_addr0  <= '0;
      mem_din0   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      elem       <= elem_nxt;
      cnt        <= cnt_nxt;
      phase      <= phase_nxt;
      drain_last <= drain_last_nxt;
      mem_csb0   <= csb_nxt;
      mem_web0   <= web_nxt;
      mem_addr0  <= addr_nxt;
      mem_din0   <= din_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    elem_nxt       = elem;
    cnt_nxt        = cnt;
    phase_nxt      = phase;
    drain_last_nxt = drain_last;
    csb_nxt        = mem_csb0;
    web_nxt        = mem_web0;
    addr_nxt       = mem_addr0;
    din_nxt        = mem_din0;
    busy_nxt       = busy;
    done_nxt       = done;
    launch         = 1'b0;
    issue_rd       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          launch    = 1'b1;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          elem_nxt  = '0;
          cnt_nxt   = '0;
          phase_nxt = 1'b0;
        end
      end
      S_RUN: begin
        csb_nxt  = 1'b0;
        web_nxt  = is_read;
        addr_nxt = op_addr;
        issue_rd = is_read;
        if (!is_read) din_nxt = op_data;
        if (two_op && !phase) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (cnt == CNT_MAX) begin
            cnt_nxt = '0;
            if (elem != 3'd5) elem_nxt = elem + 3'd1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        if (last_cmd && !(two_op && !phase)) begin
          state_nxt      = S_DRAIN;
          drain_last_nxt = 1'b0;
        end
      end
      S_DRAIN: begin
        csb_nxt        = 1'b1;
        web_nxt        = 1'b1;
        drain_last_nxt = 1'b1;
        // Second drain edge is when the final read has reached the comparator.
        if (drain_last) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read issued at E(i+1) is compared against mem_dout0 at E(i+3).
  assign mismatch = rd_v2 && (mem_dout0 != rd_exp2);

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      rd_v1   <= 1'b0;
      rd_v2   <= 1'b0;
      rd_exp1 <= '0;
      rd_exp2 <= '0;
      fail    <= 1'b0;
    end else begin
      rd_v1   <= issue_rd;
      rd_v2   <= rd_v1;
      rd_exp1 <= op_data;
      rd_exp2 <= rd_exp1;
      if (launch) fail <= 1'b0;
      else if (mismatch) fail <= 1'b1;
    end
  end

`ifdef MBIST_DIAG_EN
  logic [ADDR_WIDTH-1:0] rd_addr1, rd_addr2;
  logic [2:0]            rd_elem1, rd_elem2;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      rd_addr1  <= '0;
      rd_addr2  <= '0;
      rd_elem1  <= '0;
      rd_elem2  <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_cnt  <= '0;
    end else begin
      rd_addr1 <= op_addr;
      rd_addr2 <= rd_addr1;
      rd_elem1 <= elem;
      rd_elem2 <= rd_elem1;
      if (launch) begin
        fail_addr <= '0;
        fail_elem <= '0;
        fail_cnt  <= '0;
      end else if (mismatch) begin
        if (!fail) begin
          fail_addr <= rd_addr2;
          fail_elem <= rd_elem2;
        end
        if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
      end
    end
  end
`else
  assign fail_addr = '0;
  assign fail_elem = '0;
  assign fail_cnt  = '0;
`endif

endmodule

// File: tb/tb_sram_mbist_march_ctrl.sv
// Bench for sram_mbist_march_ctrl: behavioural SRAMs with an injectable stuck-at cell,
// checked against a March C- reference model built from the element list.
module tb_sram_mbist_march_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int N    = 1 << AW;
  localparam int NCMD = 10 * N;
  localparam logic [DW-1:0] BG_A = 32'h0000_0000;
  localparam logic [DW-1:0] BG_B = 32'h5555_5555;
  localparam logic [1:0] W0 = 2'b00, W1 = 2'b01, R0 = 2'b10, R1 = 2'b11;
`ifdef MBIST_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  logic clk0   = 1'b0;
  logic rst0_n = 1'b0;
  logic start  = 1'b0;
  logic use_b  = 1'b0;
  always #5 clk0 = ~clk0;

  logic          a_csb, a_web, a_busy, a_done, a_fail;
  logic [AW-1:0] a_addr, a_faddr;
  logic [DW-1:0] a_din, a_dout;
  logic [2:0]    a_felem;
  logic [15:0]   a_fcnt;
  logic          b_csb, b_web, b_busy, b_done, b_fail;
  logic [AW-1:0] b_addr, b_faddr;
  logic [DW-1:0] b_din, b_dout;
  logic [2:0]    b_felem;
  logic [15:0]   b_fcnt;

  sram_mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_BG(BG_A)) u_dut_a (
    .clk0(clk0), .rst0_n(rst0_n), .start(start & ~use_b),
    .mem_csb0(a_csb), .mem_web0(a_web), .mem_addr0(a_addr), .mem_din0(a_din),
    .mem_dout0(a_dout), .busy(a_busy), .done(a_done), .fail(a_fail),
    .fail_addr(a_faddr), .fail_elem(a_felem), .fail_cnt(a_fcnt));

  sram_mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_BG(BG_B)) u_dut_b (
    .clk0(clk0), .rst0_n(rst0_n), .start(start & use_b),
    .mem_csb0(b_csb), .mem_web0(b_web), .mem_addr0(b_addr), .mem_din0(b_din),
    .mem_dout0(b_dout), .busy(b_busy), .done(b_done), .fail(b_fail),
    .fail_addr(b_faddr), .fail_elem(b_felem), .fail_cnt(b_fcnt));

  // Stuck-at cell, shared by SRAM A and the reference model
  bit f_en   = 1'b0;
  int f_addr = 0;
  int f_bit  = 0;
  bit f_val  = 1'b0;

  function automatic logic [DW-1:0] stuck(input logic [DW-1:0] v, input int a);
    logic [DW-1:0] r;
    r = v;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_b [N];
  always @(posedge clk0) begin
    if (!a_csb) begin
      if (!a_web) mem_a[a_addr] <= a_din;
      else        a_dout <= stuck(mem_a[a_addr], int'(a_addr));
    end
    if (!b_csb) begin
      if (!b_web) mem_b[b_addr] <= b_din;
      else        b_dout <= mem_b[b_addr];
    end
  end

  logic          m_csb, m_web, m_busy, m_done, m_fail;
  logic [AW-1:0] m_addr, m_faddr;
  logic [DW-1:0] m_din;
  logic [2:0]    m_felem;
  logic [15:0]   m_fcnt;
  assign m_csb   = use_b ? b_csb   : a_csb;
  assign m_web   = use_b ? b_web   : a_web;
  assign m_busy  = use_b ? b_busy  : a_busy;
  assign m_done  = use_b ? b_done  : a_done;
  assign m_fail  = use_b ? b_fail  : a_fail;
  assign m_addr  = use_b ? b_addr  : a_addr;
  assign m_faddr = use_b ? b_faddr : a_faddr;
  assign m_din   = use_b ? b_din   : a_din;
  assign m_felem = use_b ? b_felem : a_felem;
  assign m_fcnt  = use_b ? b_fcnt  : a_fcnt;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: March C- as a list of elements, expanded into commands
  typedef struct {
    bit            rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            elem;
  } cmd_t;

  cmd_t          exp_q[$];
  int            first_mm;
  int            n_mm;
  logic [AW-1:0] first_addr;
  logic [2:0]    first_elem;

  function automatic int n_ops(input int e);
    return (e == 0 || e == 5) ? 1 : 2;
  endfunction

  function automatic logic [1:0] march_op(input int e, input int o);
    case (e)
      0:       return W0;
      1, 3:    return (o == 0) ? R0 : W1;
      2, 4:    return (o == 0) ? R1 : W0;
      default: return R0;
    endcase
  endfunction

  task automatic prepare(input logic [DW-1:0] bg);
    logic [DW-1:0] mdl [N];
    logic [DW-1:0] v;
    logic [1:0]    op;
    cmd_t          c;
    int            a;
    exp_q.delete();
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < N; k++)
        for (int o = 0; o < n_ops(e); o++) begin
          op     = march_op(e, o);
          a      = (e == 3 || e == 4) ? N - 1 - k : k;
          c.rd   = op[1];
          c.addr = a[AW-1:0];
          c.data = op[0] ? ~bg : bg;
          c.elem = e;
          exp_q.push_back(c);
        end
    first_mm = -1; n_mm = 0; first_addr = '0; first_elem = '0;
    foreach (exp_q[i]) begin
      if (!exp_q[i].rd) begin
        mdl[exp_q[i].addr] = exp_q[i].data;
      end else begin
        v = stuck(mdl[exp_q[i].addr], int'(exp_q[i].addr));
        if (v !== exp_q[i].data) begin
          if (first_mm < 0) begin
            first_mm   = i;
            first_addr = exp_q[i].addr;
            first_elem = 3'(exp_q[i].elem);
          end
          n_mm++;
        end
      end
    end
  endtask

  // fail is visible after edge E(k) once the first mismatching read i has i+3 <= k
  function automatic bit exp_fail(input int k);
    return (first_mm >= 0) && (first_mm + 3 <= k);
  endfunction

  function automatic logic [63:0] exp_diag();
    logic [15:0] c;
    c = (n_mm > 65535) ? 16'hFFFF : 16'(n_mm);
    return DIAG ? 64'({first_addr, first_elem, c}) : 64'd0;
  endfunction

  task automatic run_march(input string tag, input bit hold);
    logic [DW-1:0] last_w;
    last_w = '0;
    start  = 1'b1;
    @(posedge clk0); #1;
    chk({tag, " E0 status"}, 64'({m_csb, m_busy, m_done, m_fail}), 64'(4'b1100));
    chk({tag, " E0 diag"}, 64'({m_faddr, m_felem, m_fcnt}), 64'd0);
    if (!hold) start = 1'b0;
    for (int j = 0; j < NCMD; j++) begin
      @(posedge clk0); #1;
      if (!exp_q[j].rd) last_w = exp_q[j].data;
      chk($sformatf("%s cmd%0d", tag, j), 64'({m_csb, m_web, m_addr, m_din}),
          64'({1'b0, exp_q[j].rd, exp_q[j].addr, last_w}));
      chk($sformatf("%s cmd%0d status", tag, j), 64'({m_busy, m_done, m_fail}),
          64'({1'b1, 1'b0, exp_fail(j + 1)}));
    end
    @(posedge clk0); #1;
    chk({tag, " drain cmd"}, 64'({m_csb, m_web}), 64'(2'b11));
    chk({tag, " drain status"}, 64'({m_busy, m_done, m_fail}), 64'({1'b1, 1'b0, exp_fail(NCMD + 1)}));
    @(posedge clk0); #1;
    chk({tag, " done status"}, 64'({m_busy, m_done, m_fail}), 64'({1'b0, 1'b1, n_mm > 0}));
    chk({tag, " done diag"}, 64'({m_faddr, m_felem, m_fcnt}), exp_diag());
  endtask

  task automatic idle_gap(input string tag, input bit exp_done);
    int gap;
    gap = int'($urandom_range(1, 4));
    for (int g = 0; g < gap; g++) begin
      @(posedge clk0); #1;
      chk($sformatf("%s gap%0d", tag, g), 64'({m_csb, m_busy, m_done}), 64'({1'b1, 1'b0, exp_done}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk0);
    #1;
    chk("reset a", 64'({a_csb, a_web, a_addr, a_din, a_busy, a_done, a_fail}), 64'({2'b11, 4'd0, 32'd0, 3'b000}));
    chk("reset a diag", 64'({a_faddr, a_felem, a_fcnt}), 64'd0);
    chk("reset b", 64'({b_csb, b_web, b_addr, b_din, b_busy, b_done, b_fail}), 64'({2'b11, 4'd0, 32'd0, 3'b000}));
    @(negedge clk0) rst0_n = 1'b1;
    idle_gap("idle", 1'b0);

    prepare(BG_A);
    run_march("clean", 1'b0);
    idle_gap("clean sticky", 1'b1);

    f_en = 1'b1; f_addr = 3; f_bit = 5; f_val = 1'b1;
    prepare(BG_A);
    run_march("sa1_b5_a3", 1'b0);
    chk("sa1 first elem", 64'(first_elem), 64'(1));
    idle_gap("sa1 sticky", 1'b1);

    f_en  = 1'b0;
    use_b = 1'b1;
    prepare(BG_B);
    run_march("bg55", 1'b0);
    idle_gap("bg55 sticky", 1'b1);
    use_b = 1'b0;

    // Reset at command 50 of a faulty run; the partial result must vanish
    f_en = 1'b1; f_addr = 3; f_bit = 5; f_val = 1'b1;
    prepare(BG_A);
    start = 1'b1;
    @(posedge clk0); #1;
    start = 1'b0;
    for (int j = 0; j <= 50; j++) @(posedge clk0);
    #1;
    chk("pre-reset cmd50", 64'({m_csb, m_web, m_addr}), 64'({1'b0, exp_q[50].rd, exp_q[50].addr}));
    chk("pre-reset fail", 64'(m_fail), 64'(exp_fail(51)));
    #2 rst0_n = 1'b0;
    #1;
    chk("async reset", 64'({m_csb, m_web, m_addr, m_din, m_busy, m_done, m_fail}), 64'({2'b11, 4'd0, 32'd0, 3'b000}));
    chk("async reset diag", 64'({m_faddr, m_felem, m_fcnt}), 64'd0);
    @(negedge clk0) rst0_n = 1'b1;
    f_en = 1'b0;
    prepare(BG_A);
    run_march("post_reset", 1'b0);

    // start held high: random fault run, then automatic relaunch from DONE
    f_en   = 1'b1;
    f_addr = int'($urandom_range(0, N - 1));
    f_bit  = int'($urandom_range(0, DW - 1));
    f_val  = bit'($urandom_range(0, 1));
    prepare(BG_A);
    run_march($sformatf("hold_flt a%0d b%0d v%0d", f_addr, f_bit, f_val), 1'b1);
    f_en = 1'b0;
    prepare(BG_A);
    run_march("hold_clean", 1'b1);
    start = 1'b0;
    idle_gap("final", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
